// File: rtl/dmem_arbiter_if.sv
// One requester's view of the data-memory arbiter: request fields in, completion/status/read data out.
// Byte addresses and data use MSB-first bus numbering ([0] = MSB).
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic [0:AW-1] addr;
    logic [0:DW-1] wdata;
    logic          we;
    logic [1:0]    size;
    logic          done;
    logic          err;
    logic [0:DW-1] rdata;

    modport master (
        output req, addr, wdata, we, size,
        input  done, err, rdata
    );

    modport slave (
        input  req, addr, wdata, we, size,
        output done, err, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data memory: port 0 = CPU LSU, port 1 = loader/debug.
// Optional feature macro ARB_LOCK_EN adds lock0/lock1 so the last owner can keep the memory for atomic sequences.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic [0:AW-1] daddr,
    output logic [0:DW-1] dwdata,
    output logic          dwrite,
    output logic [1:0]    dsize,
    input  logic [0:DW-1] drdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    state_t        state_r;
    logic          owner_r;
    logic          rr_r;
    logic          we_r;
    logic          legal_r;
    logic [1:0]    done_r;
    logic [1:0]    err_r;
    logic [0:DW-1] rdata0_r;
    logic [0:DW-1] rdata1_r;

    logic          req_any_s;
    logic          lock_hold_s;
    logic          win_s;
    logic [0:AW-1] sel_addr_s;
    logic [0:DW-1] sel_wdata_s;
    logic          sel_we_s;
    logic [1:0]    sel_size_s;
    logic          sel_legal_s;

    // Reserved size, odd half-word, or word not on a 4-byte boundary never reaches dmem.
    function automatic logic access_legal(input logic [0:AW-1] a, input logic [1:0] s);
        logic ok;
        case (s)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (a[AW-1] == 1'b0);
            2'b10:   ok = (a[AW-2:AW-1] == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Lock hold: the last owner keeps the memory while it holds both lock and req.
`ifdef ARB_LOCK_EN
    always_comb begin
        lock_hold_s = 1'b0;
        if (rr_r) begin
            lock_hold_s = lock1 & p1.req;
        end else begin
            lock_hold_s = lock0 & p0.req;
        end
    end
`else
    assign lock_hold_s = 1'b0;
`endif

    // Winner selection and request-field mux for the IDLE decision.
    always_comb begin
        req_any_s = p0.req | p1.req;
        win_s     = 1'b0;
        if (p0.req && p1.req) begin
            if (lock_hold_s) begin
                win_s = rr_r;
            end else if (FIXED_PRI != 0) begin
                win_s = 1'b0;
            end else begin
                win_s = ~rr_r;
            end
        end else if (lock_hold_s) begin
            win_s = rr_r;
        end else if (p1.req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end

        if (win_s) begin
            sel_addr_s  = p1.addr;
            sel_wdata_s = p1.wdata;
            sel_we_s    = p1.we;
            sel_size_s  = p1.size;
        end else begin
            sel_addr_s  = p0.addr;
            sel_wdata_s = p0.wdata;
            sel_we_s    = p0.we;
            sel_size_s  = p0.size;
        end
        sel_legal_s = access_legal(sel_addr_s, sel_size_s);
    end

    // Access sequencer: IDLE latches the winner, ACCESS drives dmem, DONE reports and moves the rr pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            owner_r  <= 1'b0;
            rr_r     <= 1'b1;
            we_r     <= 1'b0;
            legal_r  <= 1'b0;
            done_r   <= 2'b00;
            err_r    <= 2'b00;
            rdata0_r <= {DW{1'b0}};
            rdata1_r <= {DW{1'b0}};
            daddr    <= {AW{1'b0}};
            dwdata   <= {DW{1'b0}};
            dsize    <= 2'b00;
            dwrite   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 2'b00;
                    err_r  <= 2'b00;
                    if (req_any_s) begin
                        owner_r <= win_s;
                        daddr   <= sel_addr_s;
                        dwdata  <= sel_wdata_s;
                        dsize   <= sel_size_s;
                        we_r    <= sel_we_s;
                        legal_r <= sel_legal_s;
                        dwrite  <= sel_we_s & sel_legal_s;
                        state_r <= ST_ACCESS;
                    end else begin
                        dwrite  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    dwrite          <= 1'b0;
                    done_r[owner_r] <= 1'b1;
                    err_r[owner_r]  <= ~legal_r;
                    if (legal_r && !we_r) begin
                        if (owner_r) begin
                            rdata1_r <= drdata;
                        end else begin
                            rdata0_r <= drdata;
                        end
                    end
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 2'b00;
                    err_r   <= 2'b00;
                    dwrite  <= 1'b0;
                    rr_r    <= owner_r;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 2'b00;
                    err_r   <= 2'b00;
                    dwrite  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign p0.done  = done_r[0];
    assign p0.err   = err_r[0];
    assign p0.rdata = rdata0_r;
    assign p1.done  = done_r[1];
    assign p1.err   = err_r[1];
    assign p1.rdata = rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected completions and dmem writes,
// a negedge monitor pops and compares whenever done or dwrite appears.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:AW-1] daddr;
    logic [0:DW-1] dwdata;
    logic          dwrite;
    logic [1:0]    dsize;
    logic [0:DW-1] drdata;
`ifdef ARB_LOCK_EN
    logic          lock0;
    logic          lock1;
`endif

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();
    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

    dmem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef ARB_LOCK_EN
        .lock0  (lock0),
        .lock1  (lock1),
`endif
        .p0     (bus0),
        .p1     (bus1),
        .daddr  (daddr),
        .dwdata (dwdata),
        .dwrite (dwrite),
        .dsize  (dsize),
        .drdata (drdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Simple word-wide dmem model with a preload path
    logic [0:31] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx;
    logic [0:31] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (dwrite) mem[daddr[22:29]] <= dwdata;
    end
    assign drdata = mem[daddr[22:29]];

    typedef struct {
        logic        port;
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wexp_t;

    exp_t  sbq[$];
    wexp_t wq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic port, input logic err, input logic chk,
                           input logic [31:0] rd, input int c);
        exp_t e;
        e.port = port; e.err = err; e.chk_rd = chk; e.rdata = rd; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic set_port(input int p, input logic req, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic we, input logic [1:0] size);
        if (p == 0) begin
            bus0.req = req; bus0.addr = addr; bus0.wdata = wdata; bus0.we = we; bus0.size = size;
        end else begin
            bus1.req = req; bus1.addr = addr; bus1.wdata = wdata; bus1.we = we; bus1.size = size;
        end
    endtask

    // Single access from IDLE: done expected two cycles after req is raised, req dropped after DONE.
    task automatic access(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic [1:0] size, input logic exp_err,
                          input logic [31:0] exp_rd);
        wexp_t w;
        set_port(p, 1'b1, addr, wdata, we, size);
        push_rd(p[0], exp_err, 1'b1, exp_rd, cyc + 2);
        if (we && !exp_err) begin
            w.addr = addr; w.data = wdata; w.cyc = cyc + 1;
            wq.push_back(w);
        end
        tick(3);
        set_port(p, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    endtask

    task automatic pop_check(input logic port, input logic err, input logic [31:0] rd);
        exp_t e;
        if (sbq.size() == 0) begin
            check("unexpected_done", {31'b0, port}, 32'hFFFF_FFFF);
        end else begin
            e = sbq.pop_front();
            check("done_port", {31'b0, port}, {31'b0, e.port});
            check("done_cycle", 32'(cyc), 32'(e.cyc));
            check("err", {31'b0, err}, {31'b0, e.err});
            if (e.chk_rd) check("rdata", rd, e.rdata);
        end
    endtask

    // Monitor: every done pulse and every dwrite cycle is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus0.done === 1'b1) pop_check(1'b0, bus0.err, bus0.rdata);
            if (bus1.done === 1'b1) pop_check(1'b1, bus1.err, bus1.rdata);
            if (dwrite === 1'b1) begin
                if (wq.size() == 0) begin
                    check("unexpected_dwrite", daddr, 32'hFFFF_FFFF);
                end else begin
                    wexp_t w;
                    w = wq.pop_front();
                    check("dwrite_addr", daddr, w.addr);
                    check("dwrite_data", dwdata, w.data);
                    check("dwrite_cycle", 32'(cyc), 32'(w.cyc));
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_done"}, {30'b0, bus1.done, bus0.done}, 32'h0);
        check({tag, "_err"}, {30'b0, bus1.err, bus0.err}, 32'h0);
        check({tag, "_rdata0"}, bus0.rdata, 32'h0);
        check({tag, "_rdata1"}, bus1.rdata, 32'h0);
        check({tag, "_daddr"}, daddr, 32'h0);
        check({tag, "_dwdata"}, dwdata, 32'h0);
        check({tag, "_dwrite_dsize"}, {29'b0, dwrite, dsize}, 32'h0);
    endtask

    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] WV = 32'h1234_5678;

    initial begin
        int c;
        rst_n = 1'b0;
        set_port(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
        set_port(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
`ifdef ARB_LOCK_EN
        lock0 = 1'b0;
        lock1 = 1'b0;
`endif
        pl_en = 1'b1; pl_idx = 8'd0; pl_data = DB;
        tick(1);
        pl_idx = 8'd1; pl_data = 32'h0;
        tick(1);
        pl_en = 1'b0;
        tick(1);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick(1);

        // 1: word read, 2: word write then read-back via port 1
        access(0, 32'h2000, 32'h0, 1'b0, 2'b10, 1'b0, DB);
        access(0, 32'h2004, WV, 1'b1, 2'b10, 1'b0, DB);
        access(1, 32'h2004, 32'h0, 1'b0, 2'b10, 1'b0, WV);

        // 3: both held, last served was port 1 -> 0,1,0,1 three cycles apart
        c = cyc;
        set_port(0, 1'b1, 32'h2000, 32'h0, 1'b0, 2'b10);
        set_port(1, 1'b1, 32'h2004, 32'h0, 1'b0, 2'b10);
        push_rd(1'b0, 1'b0, 1'b1, DB, c + 2);
        push_rd(1'b1, 1'b0, 1'b1, WV, c + 5);
        push_rd(1'b0, 1'b0, 1'b1, DB, c + 8);
        push_rd(1'b1, 1'b0, 1'b1, WV, c + 11);
        tick(12);
        set_port(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
        set_port(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);

        // legal byte at odd address and half at even address
        access(0, 32'h2003, 32'h0, 1'b0, 2'b00, 1'b0, DB);
        access(1, 32'h2002, 32'h0, 1'b0, 2'b01, 1'b0, DB);

        // 4: rejected accesses leave rData1 and dmem untouched
        access(1, 32'h2001, 32'h0, 1'b0, 2'b10, 1'b1, DB);
        access(1, 32'h2000, 32'h0, 1'b0, 2'b11, 1'b1, DB);
        access(1, 32'h2001, 32'h5555_AAAA, 1'b1, 2'b01, 1'b1, DB);
        access(1, 32'h2006, 32'h0, 1'b1, 2'b10, 1'b1, DB);
        access(0, 32'h2000, 32'h0, 1'b0, 2'b10, 1'b0, DB);

        // 5: reset while a port-0 read is in ACCESS
        set_port(0, 1'b1, 32'h2004, 32'h0, 1'b0, 2'b10);
        tick(1);
        rst_n = 1'b0;
        set_port(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
        tick(1);
        check_outputs_zero("midreset");
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // rr pointer reset to port 1: port 0 wins the first tie
        c = cyc;
        set_port(0, 1'b1, 32'h2004, 32'h0, 1'b0, 2'b10);
        set_port(1, 1'b1, 32'h2000, 32'h0, 1'b0, 2'b10);
        push_rd(1'b0, 1'b0, 1'b1, WV, c + 2);
        push_rd(1'b1, 1'b0, 1'b1, DB, c + 5);
        tick(6);
        set_port(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
        set_port(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
        tick(1);

`ifdef ARB_LOCK_EN
        // 6: port 1 locked for three back-to-back reads while port 0 waits
        c = cyc;
        lock1 = 1'b1;
        set_port(1, 1'b1, 32'h2000, 32'h0, 1'b0, 2'b10);
        set_port(0, 1'b1, 32'h2004, 32'h0, 1'b0, 2'b10);
        push_rd(1'b1, 1'b0, 1'b1, DB, c + 2);
        push_rd(1'b1, 1'b0, 1'b1, WV, c + 5);
        push_rd(1'b1, 1'b0, 1'b1, DB, c + 8);
        push_rd(1'b0, 1'b0, 1'b1, WV, c + 11);
        tick(3);
        set_port(1, 1'b1, 32'h2004, 32'h0, 1'b0, 2'b10);
        tick(3);
        set_port(1, 1'b1, 32'h2000, 32'h0, 1'b0, 2'b10);
        tick(3);
        lock1 = 1'b0;
        set_port(1, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
        tick(3);
        set_port(0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
        tick(1);
`endif

        tick(4);
        check("sb_leftover", 32'(sbq.size()), 32'h0);
        check("wq_leftover", 32'(wq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
